// File: rtl/mem_to_bram_pkg.sv
`default_nettype none
// ============================================================================
// Package  : mem_to_bram_pkg
// Purpose  : Shared constants, types and helpers for mem_to_bram_mux and its
//            round-robin arbiter.
// Contents : C_DEFAULT_DATA_WIDTH / C_DEFAULT_ADDR_WIDTH - default word sizes
//            C_MAX_CHANNELS / C_CH_ID_WIDTH           - channel-id sizing
//            rd_tag_t                                 - read-latency pipe tag
//            clog2()                                  - ceil(log2(value))
// Revision : 1.0 - initial release
// ============================================================================
package mem_to_bram_pkg;

    localparam int C_DEFAULT_DATA_WIDTH = 32;
    localparam int C_DEFAULT_ADDR_WIDTH = 32;

    // Up to eight load or store channels are supported.
    localparam int C_MAX_CHANNELS = 8;

    // ceil(log2(value)); returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    localparam int C_CH_ID_WIDTH = clog2(C_MAX_CHANNELS);

    // One stage of the read-latency pipe: was a read issued, and for whom.
    typedef struct packed {
        logic                     vld;
        logic [C_CH_ID_WIDTH-1:0] id;
    } rd_tag_t;

endpackage : mem_to_bram_pkg
`default_nettype wire

// File: rtl/mem_to_bram_mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin grant over N requesters. The winner is
//            the first asserted request at or after the pointer, searched
//            cyclically. When advance is high and a grant is made, the pointer
//            moves to the slot just after the winner.
// Ports    : clk, rst   - clock, synchronous active-high reset (pointer -> 0)
//            req[N]     - request vector
//            advance    - allow the pointer to move this cycle
//            grant[N]   - one-hot (or zero) grant
//            ptr        - current pointer state
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import mem_to_bram_pkg::*;
#(
    parameter int N         = 2,
    parameter int PTR_WIDTH = (N > 1) ? clog2(N) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic                 advance,
    output logic [N-1:0]         grant,
    output logic [PTR_WIDTH-1:0] ptr
);

    logic [PTR_WIDTH-1:0] ptr_q;
    logic [PTR_WIDTH-1:0] ptr_d;

    int w_base;
    int w_dist;
    int w_best;
    int w_win;

    // Each requester's cyclic distance from the pointer; the closest wins.
    always_comb begin
        w_base = int'(ptr_q);
        w_dist = 0;
        w_best = N;
        w_win  = -1;
        grant  = '0;
        for (int j = 0; j < N; j++) begin
            w_dist = (j >= w_base) ? (j - w_base) : (j - w_base + N);
            if (req[j] && (w_dist < w_best)) begin
                w_best = w_dist;
                w_win  = j;
            end
        end
        for (int j = 0; j < N; j++) begin
            grant[j] = (w_win == j);
        end
        ptr_d = ptr_q;
        if (advance && (w_win >= 0)) begin
            ptr_d = (w_win == N - 1) ? '0 : PTR_WIDTH'(w_win + 1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/mem_to_bram_mux.sv
`default_nettype none
// ============================================================================
// Module   : mem_to_bram_mux
// Purpose  : Multi-channel load/store front end for a dual-port BRAM.
//            Loads are arbitrated round-robin onto port 0 (read only), stores
//            round-robin onto port 1 (write only). Read data is steered back
//            to the issuing channel through a READ_LATENCY-deep tag pipe into
//            per-channel response FIFOs; per-channel credits bound the number
//            of outstanding loads so a FIFO can never overflow.
// Ports    : clk, rst                            - clock, sync active-high reset
//            ld_req_valid/ready/addr             - load requests (packed)
//            ld_resp_valid/ready/data            - load responses (packed)
//            st_req_valid/ready/addr/data        - store requests (packed)
//            ce0, we0, address0, dout0, din0     - BRAM port 0 (reads)
//            ce1, we1, address1, dout1, din1     - BRAM port 1 (writes)
// Options  : MEM_TO_BRAM_RAW_HAZARD_EN - when defined, a load whose address
//            matches the store being granted in the same cycle is held back
//            one cycle so it observes the newly written data.
// Revision : 1.0 - initial release
// ============================================================================
module mem_to_bram_mux
    import mem_to_bram_pkg::*;
#(
    parameter int DATA_WIDTH   = C_DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH   = C_DEFAULT_ADDR_WIDTH,
    parameter int NUM_LOADS    = 2,
    parameter int NUM_STORES   = 2,
    parameter int READ_LATENCY = 1,
    parameter int RESP_DEPTH   = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    // load requests
    input  logic [NUM_LOADS-1:0]             ld_req_valid,
    output logic [NUM_LOADS-1:0]             ld_req_ready,
    input  logic [NUM_LOADS*ADDR_WIDTH-1:0]  ld_req_addr,
    // load responses
    output logic [NUM_LOADS-1:0]             ld_resp_valid,
    input  logic [NUM_LOADS-1:0]             ld_resp_ready,
    output logic [NUM_LOADS*DATA_WIDTH-1:0]  ld_resp_data,
    // store requests
    input  logic [NUM_STORES-1:0]            st_req_valid,
    output logic [NUM_STORES-1:0]            st_req_ready,
    input  logic [NUM_STORES*ADDR_WIDTH-1:0] st_req_addr,
    input  logic [NUM_STORES*DATA_WIDTH-1:0] st_req_data,
    // BRAM port 0
    output logic                             ce0,
    output logic                             we0,
    output logic [ADDR_WIDTH-1:0]            address0,
    output logic [DATA_WIDTH-1:0]            dout0,
    input  logic [DATA_WIDTH-1:0]            din0,
    // BRAM port 1
    output logic                             ce1,
    output logic                             we1,
    output logic [ADDR_WIDTH-1:0]            address1,
    output logic [DATA_WIDTH-1:0]            dout1,
    input  logic [DATA_WIDTH-1:0]            din1
);

    localparam int C_LD_PTR_W  = (NUM_LOADS  > 1) ? clog2(NUM_LOADS)  : 1;
    localparam int C_ST_PTR_W  = (NUM_STORES > 1) ? clog2(NUM_STORES) : 1;
    localparam int C_FIFO_AW   = (RESP_DEPTH > 1) ? clog2(RESP_DEPTH) : 1;
    localparam int C_CNT_W     = clog2(RESP_DEPTH + 1);

    // ------------------------------------------------------------------------
    // Store path
    // ------------------------------------------------------------------------
    logic [NUM_STORES-1:0] w_st_grant;
    logic [C_ST_PTR_W-1:0] w_unused_st_ptr;
    logic [ADDR_WIDTH-1:0] w_st_addr;
    logic [DATA_WIDTH-1:0] w_st_data;

    rr_arbiter #(
        .N (NUM_STORES)
    ) u_st_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (st_req_valid),
        .advance (1'b1),
        .grant   (w_st_grant),
        .ptr     (w_unused_st_ptr)
    );

    // One-hot grant, so OR-ing the masked channels is a plain mux.
    always_comb begin
        w_st_addr = '0;
        w_st_data = '0;
        for (int j = 0; j < NUM_STORES; j++) begin
            if (w_st_grant[j]) begin
                w_st_addr = w_st_addr | st_req_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
                w_st_data = w_st_data | st_req_data[j*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign st_req_ready = w_st_grant;
    assign ce1          = |w_st_grant;
    assign we1          = |w_st_grant;
    assign address1     = w_st_addr;
    assign dout1        = w_st_data;

    // ------------------------------------------------------------------------
    // Load arbitration
    // ------------------------------------------------------------------------
    logic [NUM_LOADS-1:0]     w_ld_elig;
    logic [NUM_LOADS-1:0]     w_ld_grant;
    logic [C_LD_PTR_W-1:0]    w_unused_ld_ptr;
    logic [ADDR_WIDTH-1:0]    w_ld_addr;
    logic [C_CH_ID_WIDTH-1:0] w_ld_id;

    rr_arbiter #(
        .N (NUM_LOADS)
    ) u_ld_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (w_ld_elig),
        .advance (1'b1),
        .grant   (w_ld_grant),
        .ptr     (w_unused_ld_ptr)
    );

    always_comb begin
        w_ld_addr = '0;
        w_ld_id   = '0;
        for (int i = 0; i < NUM_LOADS; i++) begin
            if (w_ld_grant[i]) begin
                w_ld_addr = w_ld_addr | ld_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_ld_id   = C_CH_ID_WIDTH'(i);
            end
        end
    end

    assign ld_req_ready = w_ld_grant;
    assign ce0          = |w_ld_grant;
    assign we0          = 1'b0;
    assign address0     = w_ld_addr;
    assign dout0        = '0;

    // ------------------------------------------------------------------------
    // Read-latency pipe: stage 0 captures the grant, the last stage lines up
    // with valid din0.
    // ------------------------------------------------------------------------
    rd_tag_t pipe_q [READ_LATENCY];
    rd_tag_t pipe_d [READ_LATENCY];

    always_comb begin
        pipe_d[0].vld = ce0;
        pipe_d[0].id  = w_ld_id;
        for (int k = 1; k < READ_LATENCY; k++) begin
            pipe_d[k] = pipe_q[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < READ_LATENCY; k++) begin
                pipe_q[k] <= '0;
            end
        end else begin
            pipe_q <= pipe_d;
        end
    end

    logic                     w_ret_vld;
    logic [C_CH_ID_WIDTH-1:0] w_ret_id;

    assign w_ret_vld = pipe_q[READ_LATENCY-1].vld;
    assign w_ret_id  = pipe_q[READ_LATENCY-1].id;

    // ------------------------------------------------------------------------
    // Per-channel credits and response FIFOs
    // ------------------------------------------------------------------------
    for (genvar i = 0; i < NUM_LOADS; i++) begin : g_ld_ch
        logic [DATA_WIDTH-1:0] mem_q [RESP_DEPTH];
        logic [DATA_WIDTH-1:0] mem_d [RESP_DEPTH];
        logic [C_FIFO_AW-1:0]  wr_ptr_q, wr_ptr_d;
        logic [C_FIFO_AW-1:0]  rd_ptr_q, rd_ptr_d;
        logic [C_CNT_W-1:0]    count_q, count_d;
        logic [C_CNT_W-1:0]    credit_q, credit_d;
        logic                  w_push;
        logic                  w_pop;
        logic                  w_hazard;

        assign w_push = w_ret_vld && (w_ret_id == C_CH_ID_WIDTH'(i));
        assign w_pop  = ld_resp_valid[i] && ld_resp_ready[i];

`ifdef MEM_TO_BRAM_RAW_HAZARD_EN
        // Hold a load that would read the word being written this cycle.
        assign w_hazard = ce1 && (ld_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH] == address1);
`else
        assign w_hazard = 1'b0;
`endif

        // A pop in this cycle already frees its slot; counting it lets one
        // channel issue every cycle once RESP_DEPTH covers the round trip.
        // credit_q >= 1 whenever w_pop is high, so the subtraction is safe.
        assign w_ld_elig[i] = ld_req_valid[i] && !w_hazard &&
                              ((credit_q - C_CNT_W'(w_pop)) < C_CNT_W'(RESP_DEPTH));

        always_comb begin
            mem_d    = mem_q;
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = rd_ptr_q;
            count_d  = count_q;
            credit_d = credit_q;

            if (w_push) begin
                mem_d[wr_ptr_q] = din0;
                wr_ptr_d = (wr_ptr_q == C_FIFO_AW'(RESP_DEPTH - 1)) ? '0
                                                                    : wr_ptr_q + C_FIFO_AW'(1);
            end
            if (w_pop) begin
                rd_ptr_d = (rd_ptr_q == C_FIFO_AW'(RESP_DEPTH - 1)) ? '0
                                                                    : rd_ptr_q + C_FIFO_AW'(1);
            end

            if (w_push && !w_pop) begin
                count_d = count_q + C_CNT_W'(1);
            end else if (!w_push && w_pop) begin
                count_d = count_q - C_CNT_W'(1);
            end

            if (w_ld_grant[i] && !w_pop) begin
                credit_d = credit_q + C_CNT_W'(1);
            end else if (!w_ld_grant[i] && w_pop) begin
                credit_d = credit_q - C_CNT_W'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
                credit_q <= '0;
                for (int e = 0; e < RESP_DEPTH; e++) begin
                    mem_q[e] <= '0;
                end
            end else begin
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                count_q  <= count_d;
                credit_q <= credit_d;
                mem_q    <= mem_d;
            end
        end

        // Response data comes straight from FIFO storage, never from din0.
        assign ld_resp_valid[i]                          = (count_q != '0);
        assign ld_resp_data[i*DATA_WIDTH +: DATA_WIDTH]  = mem_q[rd_ptr_q];
    end

    // Port 1 is write-only; its read data is accepted but not used.
    logic w_unused_din1;
    assign w_unused_din1 = ^din1;

endmodule : mem_to_bram_mux
`default_nettype wire
